// File: rtl/c3po_router_if.sv
// Beat/chunk bus for c3po_router: one wide input beat stream in, NUM_PORTS chunk streams out.
// master = beat source and chunk sink; slave = the router.
interface c3po_router_if #(
    parameter int NUM_PORTS = 4,
    parameter int IN_BYTES  = 160,
    parameter int OUT_BYTES = 32,
    parameter int ID_W      = 4
);
    localparam int VBC_W  = $clog2(IN_BYTES + 1);
    localparam int OVBC_W = $clog2(OUT_BYTES + 1);

    logic                                   val;
    logic                                   sop;
    logic                                   eop;
    logic [ID_W-1:0]                        id;
    logic [VBC_W-1:0]                       vbc;
    logic [IN_BYTES*8-1:0]                  data;
    logic                                   in_ready;

    logic [NUM_PORTS-1:0]                   o_val;
    logic [NUM_PORTS-1:0]                   o_ready;
    logic [NUM_PORTS-1:0]                   o_sop;
    logic [NUM_PORTS-1:0]                   o_eop;
    logic [NUM_PORTS-1:0][OVBC_W-1:0]       o_vbc;
    logic [NUM_PORTS-1:0][OUT_BYTES*8-1:0]  o_data;

    modport master (
        output val, sop, eop, id, vbc, data, o_ready,
        input  in_ready, o_val, o_sop, o_eop, o_vbc, o_data
    );

    modport slave (
        input  val, sop, eop, id, vbc, data, o_ready,
        output in_ready, o_val, o_sop, o_eop, o_vbc, o_data
    );
endinterface

// File: rtl/c3po_router.sv
// Id-routed beat demux: each slice unpacks a beat into OUT_BYTES chunks with framing checks and stats.
// Optional feature macro: C3PO_DROP_CNT_EN enables the saturating dropped-beat counter.
module c3po_router #(
    parameter int NUM_PORTS  = 4,
    parameter int IN_BYTES   = 160,
    parameter int OUT_BYTES  = 32,
    parameter int ID_W       = 4,
    parameter int CNT_SIZE_P = 16,
    localparam int VBC_W     = $clog2(IN_BYTES + 1),
    localparam int OVBC_W    = $clog2(OUT_BYTES + 1),
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    c3po_router_if.slave                          bus,
    input  logic                                  cfg_we,
    input  logic [PORT_W-1:0]                     cfg_port,
    input  logic [ID_W-1:0]                       cfg_id,
    input  logic                                  cfg_en,
    input  logic [NUM_PORTS-1:0]                  cnt_clr,
    output logic [NUM_PORTS-1:0][CNT_SIZE_P-1:0]  byte_cnt,
    output logic [NUM_PORTS-1:0][CNT_SIZE_P-1:0]  pkt_cnt,
    output logic [NUM_PORTS-1:0]                  err,
    output logic [CNT_SIZE_P-1:0]                 drop_cnt,
    input  logic                                  drop_clr
);
    localparam int SUM_W = CNT_SIZE_P + 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] can_load;
    logic [NUM_PORTS-1:0] in_pkt;
    logic [NUM_PORTS-1:0] load;
    logic [NUM_PORTS-1:0] err_set;
    logic                 match;
    logic [PORT_W-1:0]    sel;
    logic                 accept;
    logic                 vbc_bad;
    logic                 frame_bad;
    logic                 drop;

    // Lowest-index enabled slice whose id matches wins.
    always_comb begin
        match = 1'b0;
        sel   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match = 1'b1;
                sel   = PORT_W'(i);
            end
        end
    end

    // Unmatched beats are always taken so they can be discarded without stalling the source.
    assign bus.in_ready = match ? can_load[sel] : 1'b1;
    assign accept       = bus.val && bus.in_ready;
    assign vbc_bad      = (bus.vbc == '0) || (bus.vbc > VBC_W'(IN_BYTES));
    assign frame_bad    = bus.sop ? in_pkt[sel] : !in_pkt[sel];
    assign drop         = accept && (!match || vbc_bad || frame_bad);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
            state_t                  state_reg;
            logic [ID_W-1:0]         cfg_id_reg;
            logic                    cfg_en_reg;
            logic [IN_BYTES*8-1:0]   data_reg;
            logic [VBC_W-1:0]        rem_reg;
            logic                    sop_reg;
            logic                    eop_reg;
            logic                    in_pkt_reg;
            logic                    err_reg;
            logic [CNT_SIZE_P-1:0]   byte_cnt_reg;
            logic [CNT_SIZE_P-1:0]   pkt_cnt_reg;
            logic [SUM_W-1:0]        byte_sum;
            logic [SUM_W-1:0]        pkt_sum;
            logic                    last;
            logic                    advance;
            logic                    sel_hit;

            assign hit[gi]      = cfg_en_reg && (cfg_id_reg == bus.id);
            // rem_reg is the byte count still to be emitted, counting the chunk on the bus.
            assign last         = rem_reg <= VBC_W'(OUT_BYTES);
            assign advance      = (state_reg == SEND) && bus.o_ready[gi];
            assign can_load[gi] = (state_reg == IDLE) || (advance && last);
            assign sel_hit      = accept && match && (sel == PORT_W'(gi));
            assign load[gi]     = sel_hit && !vbc_bad && !frame_bad;
            assign err_set[gi]  = sel_hit && (vbc_bad || frame_bad);
            assign in_pkt[gi]   = in_pkt_reg;
            assign byte_sum     = {1'b0, byte_cnt_reg} + SUM_W'(bus.vbc);
            assign pkt_sum      = {1'b0, pkt_cnt_reg} + SUM_W'(1);

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= IDLE;
                    cfg_id_reg   <= ID_W'(gi);
                    cfg_en_reg   <= 1'b0;
                    data_reg     <= '0;
                    rem_reg      <= '0;
                    sop_reg      <= 1'b0;
                    eop_reg      <= 1'b0;
                    in_pkt_reg   <= 1'b0;
                    err_reg      <= 1'b0;
                    byte_cnt_reg <= '0;
                    pkt_cnt_reg  <= '0;
                end else begin
                    if (cfg_we && (cfg_port == PORT_W'(gi))) begin
                        cfg_id_reg <= cfg_id;
                        cfg_en_reg <= cfg_en;
                    end

                    // A load on the last handshake gives back-to-back beats with no bubble.
                    if (load[gi]) begin
                        state_reg <= SEND;
                        data_reg  <= bus.data;
                        rem_reg   <= bus.vbc;
                        sop_reg   <= bus.sop;
                        eop_reg   <= bus.eop;
                    end else if (advance) begin
                        if (last) begin
                            state_reg <= IDLE;
                        end else begin
                            data_reg <= data_reg >> (OUT_BYTES * 8);
                            rem_reg  <= rem_reg - VBC_W'(OUT_BYTES);
                            sop_reg  <= 1'b0;
                        end
                    end

                    // A disabled slice forgets packet context, so re-enable must start with sop.
                    if (!cfg_en_reg) begin
                        in_pkt_reg <= 1'b0;
                    end else if (load[gi]) begin
                        in_pkt_reg <= !bus.eop;
                    end

                    if (cnt_clr[gi]) begin
                        byte_cnt_reg <= '0;
                        pkt_cnt_reg  <= '0;
                        err_reg      <= 1'b0;
                    end else begin
                        if (load[gi]) begin
                            byte_cnt_reg <= byte_sum[CNT_SIZE_P] ? '1 : byte_sum[CNT_SIZE_P-1:0];
                        end
                        if (load[gi] && bus.eop) begin
                            pkt_cnt_reg <= pkt_sum[CNT_SIZE_P] ? '1 : pkt_sum[CNT_SIZE_P-1:0];
                        end
                        if (err_set[gi]) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
            end

            assign bus.o_val[gi]  = (state_reg == SEND);
            assign bus.o_data[gi] = data_reg[OUT_BYTES*8-1:0];
            assign bus.o_vbc[gi]  = last ? rem_reg[OVBC_W-1:0] : OVBC_W'(OUT_BYTES);
            assign bus.o_sop[gi]  = (state_reg == SEND) && sop_reg;
            assign bus.o_eop[gi]  = (state_reg == SEND) && eop_reg && last;
            assign byte_cnt[gi]   = byte_cnt_reg;
            assign pkt_cnt[gi]    = pkt_cnt_reg;
            assign err[gi]        = err_reg;
        end
    endgenerate

`ifdef C3PO_DROP_CNT_EN
    logic [CNT_SIZE_P-1:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || drop_clr) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_SIZE_P'(1);
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    logic unused_drop;
    assign unused_drop = drop ^ drop_clr;
    assign drop_cnt    = '0;
`endif
endmodule

// File: tb/tb_c3po_router.sv
// Randomised self-checking bench for c3po_router against a chunk-queue reference model.
// Drop-counter expectations follow the C3PO_DROP_CNT_EN macro.
`timescale 1ns/1ps
module tb_c3po_router;
    localparam int NP     = 4;
    localparam int IB     = 160;
    localparam int OB     = 32;
    localparam int IDW    = 4;
    localparam int CW     = 16;
    localparam int VBC_W  = 8;
    localparam int OVBC_W = 6;
    localparam int PW     = 2;
    localparam int CMAX   = 65535;

    typedef struct packed {
        logic [OB*8-1:0] data;
        logic [7:0]      vbc;
        logic            sop;
        logic            eop;
    } chunk_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    cfg_we;
    logic [PW-1:0]           cfg_port;
    logic [IDW-1:0]          cfg_id;
    logic                    cfg_en;
    logic [NP-1:0]           cnt_clr;
    logic                    drop_clr;
    logic [NP-1:0][CW-1:0]   byte_cnt;
    logic [NP-1:0][CW-1:0]   pkt_cnt;
    logic [NP-1:0]           err;
    logic [CW-1:0]           drop_cnt;

    c3po_router_if #(.NUM_PORTS(NP), .IN_BYTES(IB), .OUT_BYTES(OB), .ID_W(IDW)) bus ();

    c3po_router #(.NUM_PORTS(NP), .IN_BYTES(IB), .OUT_BYTES(OB), .ID_W(IDW), .CNT_SIZE_P(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cfg_we   (cfg_we),
        .cfg_port (cfg_port),
        .cfg_id   (cfg_id),
        .cfg_en   (cfg_en),
        .cnt_clr  (cnt_clr),
        .byte_cnt (byte_cnt),
        .pkt_cnt  (pkt_cnt),
        .err      (err),
        .drop_cnt (drop_cnt),
        .drop_clr (drop_clr)
    );

    always #5 clk = ~clk;

    // Reference model: per-port queue of chunks still owed downstream, plus config and stats.
    chunk_t          mq [NP][$];
    logic [IDW-1:0]  m_id [NP];
    bit              m_en [NP];
    bit              m_inpkt [NP];
    bit              m_err [NP];
    int              m_byte [NP];
    int              m_pkt [NP];
    int              m_drop;
    int              n_tests = 0;
    int              n_fail  = 0;
    bit              rand_ready = 1'b0;
    bit              last_accept;

    function automatic logic [IB*8-1:0] rand_data();
        logic [IB*8-1:0] d;
        for (int w = 0; w < IB / 4; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            m_id[i]    = IDW'(i);
            m_en[i]    = 1'b0;
            m_inpkt[i] = 1'b0;
            m_err[i]   = 1'b0;
            m_byte[i]  = 0;
            m_pkt[i]   = 0;
        end
        m_drop = 0;
    endfunction

    // One clock: compare every output with the model, then advance the model across the edge.
    task automatic cycle();
        int     sel;
        int     v;
        bit     exp_rdy;
        bit     bad;
        chunk_t c;
        if (rand_ready) bus.o_ready = NP'($urandom);
        #1;
        for (int i = 0; i < NP; i++) begin
            n_tests++;
            if (bus.o_val[i] !== (mq[i].size() > 0)) begin
                n_fail++;
                $display("FAIL o_val[%0d] got %b required %b at %0t", i, bus.o_val[i], mq[i].size() > 0, $time);
            end
            if (mq[i].size() > 0) begin
                n_tests++;
                if (bus.o_data[i] !== mq[i][0].data || bus.o_vbc[i] !== OVBC_W'(mq[i][0].vbc) ||
                    bus.o_sop[i] !== mq[i][0].sop || bus.o_eop[i] !== mq[i][0].eop) begin
                    n_fail++;
                    $display("FAIL chunk[%0d] got vbc=%0d sop=%b eop=%b data=%h required vbc=%0d sop=%b eop=%b data=%h",
                             i, bus.o_vbc[i], bus.o_sop[i], bus.o_eop[i], bus.o_data[i],
                             mq[i][0].vbc, mq[i][0].sop, mq[i][0].eop, mq[i][0].data);
                end
            end
            n_tests++;
            if (byte_cnt[i] !== CW'(m_byte[i]) || pkt_cnt[i] !== CW'(m_pkt[i]) || err[i] !== m_err[i]) begin
                n_fail++;
                $display("FAIL stats[%0d] got byte=%0d pkt=%0d err=%b required byte=%0d pkt=%0d err=%b",
                         i, byte_cnt[i], pkt_cnt[i], err[i], m_byte[i], m_pkt[i], m_err[i]);
            end
        end
        n_tests++;
        if (drop_cnt !== CW'(m_drop)) begin
            n_fail++;
            $display("FAIL drop_cnt got %0d required %0d", drop_cnt, m_drop);
        end

        sel = -1;
        for (int i = 0; i < NP; i++) if (sel < 0 && m_en[i] && m_id[i] == bus.id) sel = i;
        exp_rdy = (sel < 0) ? 1'b1 : (mq[sel].size() == 0 || (mq[sel].size() == 1 && bus.o_ready[sel]));
        n_tests++;
        if (bus.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready got %b required %b at %0t", bus.in_ready, exp_rdy, $time);
        end
        last_accept = bus.val && exp_rdy;

        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < NP; i++) if (mq[i].size() > 0 && bus.o_ready[i]) void'(mq[i].pop_front());
            if (last_accept) begin
                v = int'(bus.vbc);
                if (sel < 0) bad = 1'b1;
                else bad = (v == 0) || (v > IB) || (bus.sop && m_inpkt[sel]) || (!bus.sop && !m_inpkt[sel]);
                if (bad) begin
                    if (sel >= 0) m_err[sel] = 1'b1;
`ifdef C3PO_DROP_CNT_EN
                    if (m_drop < CMAX) m_drop++;
`endif
                end else begin
                    for (int k = 0; k * OB < v; k++) begin
                        c.data = bus.data[k*OB*8 +: OB*8];
                        c.vbc  = 8'((v - k*OB > OB) ? OB : v - k*OB);
                        c.sop  = bus.sop && (k == 0);
                        c.eop  = bus.eop && ((k + 1) * OB >= v);
                        mq[sel].push_back(c);
                    end
                    m_inpkt[sel] = !bus.eop;
                    m_byte[sel]  = (m_byte[sel] + v > CMAX) ? CMAX : m_byte[sel] + v;
                    if (bus.eop && m_pkt[sel] < CMAX) m_pkt[sel]++;
                end
                $display("[TB] beat id=%0d vbc=%0d sop=%b eop=%b port=%0d %s",
                         bus.id, v, bus.sop, bus.eop, sel, bad ? "dropped" : "loaded");
            end
            if (cfg_we) begin
                m_id[cfg_port] = cfg_id;
                m_en[cfg_port] = cfg_en;
                if (!cfg_en) m_inpkt[cfg_port] = 1'b0;
            end
            for (int i = 0; i < NP; i++) begin
                if (cnt_clr[i]) begin
                    m_byte[i] = 0;
                    m_pkt[i]  = 0;
                    m_err[i]  = 1'b0;
                end
            end
`ifdef C3PO_DROP_CNT_EN
            if (drop_clr) m_drop = 0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.val = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg_write(input int port, input int id, input bit en);
        cfg_we   = 1'b1;
        cfg_port = PW'(port);
        cfg_id   = IDW'(id);
        cfg_en   = en;
        cycle();
        cfg_we   = 1'b0;
    endtask

    task automatic clr_all();
        cnt_clr  = '1;
        drop_clr = 1'b1;
        cycle();
        cnt_clr  = '0;
        drop_clr = 1'b0;
    endtask

    task automatic send_beat(input int id, input bit sop, input bit eop, input int vbc, input int max_cyc);
        int n;
        n        = 0;
        bus.val  = 1'b1;
        bus.id   = IDW'(id);
        bus.sop  = sop;
        bus.eop  = eop;
        bus.vbc  = VBC_W'(vbc);
        bus.data = rand_data();
        do begin
            cycle();
            n++;
        end while (!last_accept && n < max_cyc);
        bus.val = 1'b0;
        if (!last_accept) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout id=%0d got no accept in %0d cycles required accept", id, max_cyc);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (bus.o_val !== '0 || bus.o_sop !== '0 || bus.o_eop !== '0 || bus.o_vbc[0] !== '0 ||
            bus.o_data[0] !== '0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs got o_val=%b o_vbc0=%0d in_ready=%b required o_val=0 o_vbc0=0 in_ready=1",
                     bus.o_val, bus.o_vbc[0], bus.in_ready);
        end
        n_tests++;
        if (byte_cnt !== '0 || pkt_cnt !== '0 || err !== '0 || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_stats got byte=%h pkt=%h err=%b drop=%0d required all 0",
                     byte_cnt, pkt_cnt, err, drop_cnt);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_basic();
        cfg_write(0, 3, 1'b1);
        clr_all();
        bus.o_ready = '1;
        send_beat(3, 1'b1, 1'b1, 70, 4);
        #1;
        n_tests++;
        if (bus.o_val[0] !== 1'b1 || bus.o_vbc[0] !== 6'd32 || bus.o_sop[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency got o_val=%b o_vbc=%0d o_sop=%b required 1 32 1",
                     bus.o_val[0], bus.o_vbc[0], bus.o_sop[0]);
        end
        idle(4);
        n_tests++;
        if (byte_cnt[0] !== 16'd70 || pkt_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_stats got byte=%0d pkt=%0d required 70 1", byte_cnt[0], pkt_cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        clr_all();
        bus.o_ready[0] = 1'b0;
        send_beat(3, 1'b1, 1'b1, 70, 4);
        bus.val  = 1'b1;
        bus.id   = 4'd3;
        bus.sop  = 1'b1;
        bus.eop  = 1'b1;
        bus.vbc  = 8'd40;
        bus.data = rand_data();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready cycle %0d got %b required 0", c, bus.in_ready);
            end
            cycle();
        end
        bus.o_ready[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== (c == 2)) begin
                n_fail++;
                $display("FAIL b2b_in_ready cycle %0d got %b required %b", c, bus.in_ready, c == 2);
            end
            cycle();
        end
        idle(4);
        n_tests++;
        if (byte_cnt[0] !== 16'd110 || pkt_cnt[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_stats got byte=%0d pkt=%0d required 110 2", byte_cnt[0], pkt_cnt[0]);
        end
    endtask

    task automatic test_multi_beat();
        clr_all();
        send_beat(3, 1'b1, 1'b0, 160, 4);
        send_beat(3, 1'b0, 1'b1, 10, 10);
        idle(4);
        n_tests++;
        if (byte_cnt[0] !== 16'd170 || pkt_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL multi_stats got byte=%0d pkt=%0d required 170 1", byte_cnt[0], pkt_cnt[0]);
        end
    endtask

    task automatic test_framing();
        int exp_drop;
        clr_all();
        send_beat(3, 1'b0, 1'b1, 40, 4);
        idle(2);
`ifdef C3PO_DROP_CNT_EN
        exp_drop = 1;
`else
        exp_drop = 0;
`endif
        n_tests++;
        if (err[0] !== 1'b1 || drop_cnt !== CW'(exp_drop) || byte_cnt[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL nosop_drop got err=%b drop=%0d byte=%0d required 1 %0d 0",
                     err[0], drop_cnt, byte_cnt[0], exp_drop);
        end
        cnt_clr[0] = 1'b1;
        cycle();
        cnt_clr[0] = 1'b0;
        n_tests++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got %b required 0", err[0]);
        end
        send_beat(3, 1'b1, 1'b1, 0, 4);
        send_beat(3, 1'b1, 1'b1, 161, 4);
        send_beat(3, 1'b1, 1'b0, 32, 4);
        send_beat(3, 1'b1, 1'b1, 20, 4);
        send_beat(3, 1'b0, 1'b1, 8, 4);
        idle(3);
        n_tests++;
        if (err[0] !== 1'b1 || byte_cnt[0] !== 16'd40 || pkt_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL framing_stats got err=%b byte=%0d pkt=%0d required 1 40 1",
                     err[0], byte_cnt[0], pkt_cnt[0]);
        end
    endtask

    task automatic test_nomatch();
        clr_all();
        #1;
        bus.id = 4'd9;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nomatch_in_ready got %b required 1", bus.in_ready);
        end
        send_beat(9, 1'b1, 1'b1, 50, 2);
        idle(2);
        n_tests++;
        if (byte_cnt !== '0 || pkt_cnt !== '0 || err !== '0) begin
            n_fail++;
            $display("FAIL nomatch_stats got byte=%h pkt=%h err=%b required all 0", byte_cnt, pkt_cnt, err);
        end
    endtask

    task automatic test_disable();
        clr_all();
        cfg_write(1, 5, 1'b1);
        bus.o_ready[1] = 1'b0;
        send_beat(5, 1'b1, 1'b0, 64, 4);
        cfg_write(1, 5, 1'b0);
        bus.o_ready[1] = 1'b1;
        idle(4);
        send_beat(5, 1'b0, 1'b1, 20, 4);
        cfg_write(1, 5, 1'b1);
        send_beat(5, 1'b0, 1'b1, 20, 4);
        send_beat(5, 1'b1, 1'b1, 20, 4);
        idle(3);
        n_tests++;
        if (err[1] !== 1'b1 || byte_cnt[1] !== 16'd84 || pkt_cnt[1] !== 16'd1) begin
            n_fail++;
            $display("FAIL disable_stats got err=%b byte=%0d pkt=%0d required 1 84 1",
                     err[1], byte_cnt[1], pkt_cnt[1]);
        end
    endtask

    task automatic test_reset_mid();
        bus.o_ready = '1;
        send_beat(3, 1'b1, 1'b1, 160, 4);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.o_val !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got o_val=%b required 0", bus.o_val);
        end
        idle(2);
    endtask

    task automatic test_random();
        int ids [5];
        ids = '{3, 5, 7, 9, 3};
        cfg_write(0, 3, 1'b1);
        cfg_write(1, 5, 1'b1);
        cfg_write(2, 7, 1'b1);
        cfg_write(3, 3, 1'b1);
        rand_ready = 1'b1;
        for (int b = 0; b < 300; b++) begin
            if ($urandom_range(0, 19) == 0) begin
                cnt_clr  = NP'($urandom);
                drop_clr = 1'($urandom);
                cycle();
                cnt_clr  = '0;
                drop_clr = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) begin
                cfg_write(int'($urandom_range(0, NP - 1)), ids[$urandom_range(0, 4)], $urandom_range(0, 3) != 0);
            end
            send_beat($urandom_range(0, 7) == 0 ? int'($urandom_range(0, 15)) : ids[$urandom_range(0, 4)],
                      1'($urandom), 1'($urandom),
                      $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(1, IB)),
                      200);
        end
        rand_ready  = 1'b0;
        bus.o_ready = '1;
        idle(8);
    endtask

    task automatic test_saturation();
        cfg_write(0, 3, 1'b1);
        cfg_write(3, 2, 1'b0);
        clr_all();
        bus.o_ready = '1;
        for (int b = 0; b < 1000; b++) send_beat(3, 1'b1, 1'b1, 160, 10);
        idle(6);
        n_tests++;
        if (byte_cnt[0] !== 16'hFFFF || pkt_cnt[0] !== 16'd1000) begin
            n_fail++;
            $display("FAIL saturation got byte=%h pkt=%0d required ffff 1000", byte_cnt[0], pkt_cnt[0]);
        end
        cnt_clr[0] = 1'b1;
        send_beat(3, 1'b1, 1'b1, 160, 1);
        cnt_clr[0] = 1'b0;
        n_tests++;
        if (byte_cnt[0] !== 16'd0 || pkt_cnt[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_wins got byte=%0d pkt=%0d required 0 0", byte_cnt[0], pkt_cnt[0]);
        end
        idle(6);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_port    = '0;
        cfg_id      = '0;
        cfg_en      = 1'b0;
        cnt_clr     = '0;
        drop_clr    = 1'b0;
        bus.val     = 1'b0;
        bus.sop     = 1'b0;
        bus.eop     = 1'b0;
        bus.id      = '0;
        bus.vbc     = '0;
        bus.data    = '0;
        bus.o_ready = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_multi_beat();
        test_framing();
        test_nomatch();
        test_disable();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
